otsu_block_threshold_pe: RTL and testbench

- Parametrised successor of the block-wise Otsu thresholding processing element.
- Reads one block of BLOCK_PIXELS pixels from an upstream synchronous FIFO and builds a full-precision histogram.
- Runs an exact, division-free Otsu search over all bins, then reads and binarises the next BLOCK_PIXELS pixels against the computed threshold.
- Sits between the pixel FIFO and the binary-image writer; one block per start command.

---
 rtl/otsu_block_threshold_pe.sv | 220 ++++++++++++++++++++++
 tb/tb_otsu_block_threshold_pe.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/otsu_block_threshold_pe.sv
// otsu_block_threshold_pe
//   Block-wise Otsu thresholding processing element. Per start command it
//   clears a 2^PIX_W-bin histogram, fills it from BLOCK_PIXELS FIFO pixels,
//   runs an exact division-free Otsu search (one candidate per cycle), then
//   binarises the next BLOCK_PIXELS FIFO pixels against the threshold found.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, invert     block start (IDLE only); invert latched at start
//   pixel_in          FIFO read data, valid the cycle after fifo_rd_en
//   fifo_empty        FIFO has no data
//   fifo_rd_en        FIFO pop request
//   busy              high outside IDLE
//   threshold         last computed threshold
//   thresh_valid      threshold belongs to the current block
//   degenerate        last block had no valid split
//   pixel_out/valid   binarised pixel and its qualifier
//   done              one-cycle pulse after the last binarised pixel
module otsu_block_threshold_pe #(
  parameter int PIX_W          = 8,
  parameter int BLOCK_PIXELS   = 1024,
  parameter int CNT_W          = $clog2(BLOCK_PIXELS + 1),
  parameter int DEFAULT_THRESH = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             invert,
  input  logic [PIX_W-1:0] pixel_in,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic             busy,
  output logic [PIX_W-1:0] threshold,
  output logic             thresh_valid,
  output logic             degenerate,
  output logic             pixel_out,
  output logic             pixel_valid,
  output logic             done
);

  localparam int BINS  = 1 << PIX_W;
  localparam int SUM_W = PIX_W + CNT_W;
  localparam int PRD_W = SUM_W + CNT_W;
  localparam int NUM_W = 2 * PRD_W;
  localparam int DEN_W = 2 * CNT_W;
  localparam int CMP_W = NUM_W + DEN_W;
  localparam logic [CNT_W-1:0] N_C    = CNT_W'(BLOCK_PIXELS);
  localparam logic [PIX_W-1:0] LAST_T = PIX_W'(BINS - 2);
  localparam logic [PIX_W-1:0] DEF_T  = PIX_W'(DEFAULT_THRESH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_HIST, S_SEARCH, S_DECIDE, S_BIN, S_DONE
  } state_t;

  state_t state, state_n;

  logic [CNT_W-1:0] hist [BINS];
  logic [PIX_W-1:0] bin_idx;
  logic [CNT_W-1:0] rd_cnt, rx_cnt;
  logic             rd_pending;
  logic             inv_q;
  logic [SUM_W-1:0] sum, sum_b;
  logic [CNT_W-1:0] w_b;
  logic [NUM_W-1:0] num_best;
  logic [DEN_W-1:0] den_best;
  logic             found;
  logic [PIX_W-1:0] t_best;

  logic             rx_last;
  logic [CNT_W-1:0] hist_t, w_b_n, w_f_n;
  logic [SUM_W-1:0] sum_b_n;
  logic [PRD_W-1:0] prod_a, prod_b, mag;
  logic [NUM_W-1:0] num;
  logic [DEN_W-1:0] den;
  logic             win;

  assign rx_last = rd_pending && (rx_cnt == N_C - 1'b1);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    fifo_rd_en = 1'b0;
    case (state)
      S_IDLE:   if (start) state_n = S_CLEAR;
      S_CLEAR:  if (bin_idx == '1) state_n = S_HIST;
      S_HIST: begin
        fifo_rd_en = !fifo_empty && (rd_cnt < N_C);
        if (rx_last) state_n = S_SEARCH;
      end
      S_SEARCH: if (bin_idx == LAST_T) state_n = S_DECIDE;
      S_DECIDE: state_n = S_BIN;
      S_BIN: begin
        fifo_rd_en = !fifo_empty && (rd_cnt < N_C);
        if (rx_last) state_n = S_DONE;
      end
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (reset) fifo_rd_en = 1'b0;
  end

  // Otsu candidate t = bin_idx. Between-class variance is compared as
  // cross-multiplied fractions: num/den > num_best/den_best.
  always_comb begin
    hist_t  = hist[bin_idx];
    w_b_n   = w_b + hist_t;
    sum_b_n = sum_b + SUM_W'(bin_idx) * SUM_W'(hist_t);
    w_f_n   = N_C - w_b_n;
    prod_a  = PRD_W'(N_C) * PRD_W'(sum_b_n);
    prod_b  = PRD_W'(sum) * PRD_W'(w_b_n);
    mag     = (prod_a >= prod_b) ? (prod_a - prod_b) : (prod_b - prod_a);
    num     = NUM_W'(mag) * NUM_W'(mag);
    den     = DEN_W'(w_b_n) * DEN_W'(w_f_n);
    win     = (w_b_n != '0) && (w_f_n != '0) &&
              (CMP_W'(num) * CMP_W'(den_best) > CMP_W'(num_best) * CMP_W'(den));
  end

  // Histogram update is a single-cycle read-modify-write at the returned
  // pixel's address, so back-to-back identical pixels never lose a count.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      hist[bin_idx] <= '0;
    else if (state == S_HIST && rd_pending)
      hist[pixel_in] <= hist[pixel_in] + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_idx      <= '0;
      rd_cnt       <= '0;
      rx_cnt       <= '0;
      rd_pending   <= 1'b0;
      inv_q        <= 1'b0;
      sum          <= '0;
      sum_b        <= '0;
      w_b          <= '0;
      num_best     <= '0;
      den_best     <= DEN_W'(1);
      found        <= 1'b0;
      t_best       <= '0;
      threshold    <= DEF_T;
      thresh_valid <= 1'b0;
      degenerate   <= 1'b0;
      pixel_out    <= 1'b0;
      pixel_valid  <= 1'b0;
      done         <= 1'b0;
    end else begin
      rd_pending  <= fifo_rd_en;
      pixel_valid <= 1'b0;
      done        <= 1'b0;
      if (fifo_rd_en) rd_cnt <= rd_cnt + 1'b1;
      if (rd_pending) rx_cnt <= rx_cnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            inv_q        <= invert;
            thresh_valid <= 1'b0;
            degenerate   <= 1'b0;
            bin_idx      <= '0;
            rd_cnt       <= '0;
            rx_cnt       <= '0;
            sum          <= '0;
          end
        end
        S_CLEAR: bin_idx <= bin_idx + 1'b1;
        S_HIST: begin
          if (rd_pending) sum <= sum + SUM_W'(pixel_in);
          if (rx_last) begin
            rd_cnt   <= '0;
            rx_cnt   <= '0;
            bin_idx  <= '0;
            sum_b    <= '0;
            w_b      <= '0;
            num_best <= '0;
            den_best <= DEN_W'(1);
            found    <= 1'b0;
            t_best   <= '0;
          end
        end
        S_SEARCH: begin
          w_b     <= w_b_n;
          sum_b   <= sum_b_n;
          bin_idx <= bin_idx + 1'b1;
          if (win) begin
            num_best <= num;
            den_best <= den;
            found    <= 1'b1;
            t_best   <= bin_idx;
          end
        end
        S_DECIDE: begin
          thresh_valid <= 1'b1;
          if (found) begin
            threshold <= t_best + 1'b1;
          end else begin
            threshold  <= DEF_T;
            degenerate <= 1'b1;
          end
        end
        S_BIN: begin
          if (rd_pending) begin
            pixel_valid <= 1'b1;
            pixel_out   <= (pixel_in >= threshold) ^ inv_q;
          end
          if (rx_last) begin
            rd_cnt <= '0;
            rx_cnt <= '0;
          end
        end
        S_DONE:  done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_otsu_block_threshold_pe.sv
// Bench for otsu_block_threshold_pe: FIFO model, table of directed blocks,
// reset/start-ignore sequences and random blocks against an Otsu model.
module tb_otsu_block_threshold_pe;
  localparam int N  = 1024;
  localparam int NB = 256;

  logic clk = 1'b0;
  logic reset, start, invert, fifo_empty, fifo_rd_en, busy;
  logic thresh_valid, degenerate, pixel_out, pixel_valid, done;
  logic [7:0] pixel_in, threshold;

  always #5 clk = ~clk;

  otsu_block_threshold_pe #(
    .PIX_W(8), .BLOCK_PIXELS(N), .DEFAULT_THRESH(128)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .invert(invert),
    .pixel_in(pixel_in), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .busy(busy), .threshold(threshold), .thresh_valid(thresh_valid),
    .degenerate(degenerate), .pixel_out(pixel_out), .pixel_valid(pixel_valid),
    .done(done)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] px [2*N];
  logic [7:0] fq [$];
  bit   outq [$];
  int   pops = 0;
  int   viol = 0;
  int   done_cnt = 0;
  bit   stall_en = 0;

  typedef struct {
    int cnt_a; int val_a; int val_b;
    bit inv; bit stall; bit mid;
    int exp_thr; int exp_deg;
    int b0; int exp_out0;
  } vec_t;
  vec_t vt [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // FIFO model: pop decided by rd_en seen mid-cycle, data presented after the edge
  initial begin : fifo_drv
    bit rd;
    fifo_empty = 1'b1;
    pixel_in   = '0;
    forever begin
      @(negedge clk);
      rd = fifo_rd_en;
      if (rd && fifo_empty) viol++;
      @(posedge clk);
      #1;
      if (rd && fq.size() > 0) begin
        pixel_in = fq.pop_front();
        pops++;
      end
      fifo_empty = (fq.size() == 0) || (stall_en && $urandom_range(0, 1) == 1);
    end
  end

  always @(negedge clk) begin
    if (pixel_valid) outq.push_back(pixel_out);
    if (done) done_cnt++;
  end

  // Otsu reference: for each t recompute class weights and sums from scratch
  task automatic model(output int thr, output bit deg);
    int h [NB];
    longint tot, wb, wf, sb, d;
    logic [127:0] nb, db, nm, dn;
    foreach (h[i]) h[i] = 0;
    tot = 0;
    for (int i = 0; i < N; i++) begin
      h[px[i]]++;
      tot += px[i];
    end
    nb = 0; db = 1; thr = 128; deg = 1;
    for (int t = 0; t < NB - 1; t++) begin
      wb = 0; sb = 0;
      for (int i = 0; i <= t; i++) begin
        wb += h[i];
        sb += longint'(i) * h[i];
      end
      wf = N - wb;
      if (wb == 0 || wf == 0) continue;
      d  = N * sb - tot * wb;
      nm = 128'(d * d);
      dn = 128'(wb * wf);
      if (nm * db > nb * dn) begin
        nb = nm; db = dn; thr = t + 1; deg = 0;
      end
    end
  endtask

  task automatic fill(input int cnt_a, input int val_a, input int val_b);
    for (int i = 0; i < N; i++) px[i] = 8'((i < cnt_a) ? val_a : val_b);
    for (int i = N; i < 2*N; i++) px[i] = 8'($urandom_range(0, 255));
    px[N+1] = 8'd41;
    px[N+2] = 8'd200;
  endtask

  task automatic run(input bit inv, input bit stall, input bit mid,
                     input int exp_thr, input int exp_deg, input string tag);
    int mthr, cyc, bad;
    bit mdeg, s1, s2;
    fq.delete();
    for (int i = 0; i < 2*N; i++) fq.push_back(px[i]);
    pops = 0; done_cnt = 0; stall_en = stall;
    outq.delete();
    invert = inv; start = 1'b1;
    tick;
    start = 1'b0; invert = 1'b0;
    check({tag, "_tv_drop"}, thresh_valid, 0);
    check({tag, "_busy"}, busy, 1);
    cyc = 0; s1 = 0; s2 = 0;
    while (done_cnt == 0 && cyc < 30000) begin
      if (mid && !s1 && pops == N) begin
        repeat (60) tick;
        start = 1'b1; tick; start = 1'b0;
        s1 = 1; cyc += 61;
      end else if (mid && !s2 && pops == N + 100) begin
        check({tag, "_tv_in_bin"}, thresh_valid, 1);
        start = 1'b1; tick; start = 1'b0;
        s2 = 1; cyc++;
      end else begin
        tick; cyc++;
      end
    end
    check({tag, "_done_seen"}, done_cnt != 0, 1);
    repeat (3) tick;
    model(mthr, mdeg);
    check({tag, "_thr_model"}, threshold, mthr);
    check({tag, "_deg_model"}, degenerate, mdeg);
    if (exp_thr >= 0) begin
      check({tag, "_thr"}, threshold, exp_thr);
      check({tag, "_deg"}, degenerate, exp_deg);
    end
    check({tag, "_tv"}, thresh_valid, 1);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_pops"}, pops, 2*N);
    check({tag, "_nout"}, outq.size(), N);
    check({tag, "_done_once"}, done_cnt, 1);
    bad = 0;
    for (int i = 0; i < outq.size() && i < N; i++)
      if (outq[i] !== ((px[N+i] >= 8'(mthr)) ^ inv)) bad++;
    check({tag, "_binarise"}, bad, 0);
    if (mid) begin
      repeat (20) tick;
      check({tag, "_tv_hold"}, thresh_valid, 1);
      check({tag, "_still_idle"}, busy, 0);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_tv"}, thresh_valid, 0);
    check({tag, "_thr"}, threshold, 128);
    check({tag, "_deg"}, degenerate, 0);
    check({tag, "_pv"}, pixel_valid, 0);
    check({tag, "_done"}, done, 0);
  endtask

  initial begin
    int p0, cyc;
    reset = 1'b1; start = 1'b0; invert = 1'b0;
    repeat (3) tick;
    check_reset_vals("rst0");
    reset = 1'b0;
    tick;

    vt[0] = '{512,  40, 200, 0, 0, 0, 41,  0, 40,  0};
    vt[1] = '{1024, 77, 77,  0, 0, 0, 128, 1, 77,  0};
    vt[2] = '{1024, 77, 77,  1, 0, 0, 128, 1, 77,  1};
    vt[3] = '{1024, 255, 255, 0, 0, 0, 128, 1, 255, 1};
    vt[4] = '{300,  10, 180, 0, 1, 0, 11,  0, 10,  0};
    vt[5] = '{512,  40, 200, 0, 0, 1, 41,  0, 41,  1};

    for (int v = 0; v < 6; v++) begin
      fill(vt[v].cnt_a, vt[v].val_a, vt[v].val_b);
      px[N] = 8'(vt[v].b0);
      run(vt[v].inv, vt[v].stall, vt[v].mid, vt[v].exp_thr, vt[v].exp_deg,
          $sformatf("vec%0d", v));
      if (outq.size() > 0) check($sformatf("vec%0d_out0", v), outq[0], vt[v].exp_out0);
      if (v == 0 && outq.size() > 2) begin
        check("vec0_out1", outq[1], 1);
        check("vec0_out2", outq[2], 1);
      end
    end
    check("no_pop_when_empty", viol, 0);

    // reset in the middle of HIST, then a clean block must not see stale counts
    fill(512, 40, 200);
    fq.delete();
    for (int i = 0; i < 2*N; i++) fq.push_back(px[i]);
    pops = 0; stall_en = 0;
    start = 1'b1; tick; start = 1'b0;
    cyc = 0;
    while (pops < 500 && cyc < 5000) begin tick; cyc++; end
    check("rstmid_reached", pops >= 500, 1);
    reset = 1'b1;
    tick; tick;
    p0 = pops;
    tick;
    check_reset_vals("rstmid");
    check("rstmid_no_pops", pops, p0);
    reset = 1'b0;
    tick;
    run(0, 0, 0, 41, 0, "after_rst");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 2*N; i++) px[i] = 8'($urandom_range(0, 255));
      if (r == 1) for (int i = 0; i < N; i++) px[i] = 8'((i % 3 == 0) ? $urandom_range(0, 60) : $urandom_range(150, 255));
      run(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, -1, 0, $sformatf("rnd%0d", r));
    end
    check("no_pop_when_empty_end", viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
